// File: rtl/score_display_ctrl.sv
// score_display_ctrl: owns BCD score/high score and selects what the seven-segment driver shows.
module score_display_ctrl #(
  parameter int ALT_PERIOD   = 200_000_000,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        inc_valid,
  input  logic [3:0]  inc_amt,
  output logic [15:0] disp_bcd,
  output logic        blank,
  output logic        disp_sel,
  output logic        new_high,
  output logic [1:0]  state
);
  localparam int AW = $clog2(ALT_PERIOD + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam logic [AW-1:0] ALT_LAST = AW'(ALT_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, PLAY, SHOW_SCORE, SHOW_HIGH} state_t;
  state_t st, st_nx;
  logic [15:0] score, score_nx, high, high_nx, sum, score_inc, disp_nx;
  logic [AW-1:0] alt_cnt, alt_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic [4:0] dig;
  logic [3:0] amt9;
  logic cy, blank_nx, new_high_nx, sel_nx;
  assign state = st;
  assign amt9 = (inc_amt > 4'd9) ? 4'd9 : inc_amt;
  // BCD ripple add of the clamped amount; carry out of thousands saturates
  always_comb begin
    sum = '0;
    cy = 1'b0;
    dig = '0;
    for (int i = 0; i < 4; i++) begin
      dig = {1'b0, score[4*i+:4]} + {1'b0, (i == 0) ? amt9 : 4'd0} + {4'd0, cy};
      cy = dig > 5'd9;
      sum[4*i+:4] = cy ? 4'(dig - 5'd10) : dig[3:0];
    end
    if (cy) sum = 16'h9999;
  end
  assign score_inc = inc_valid ? sum : score;
  always_comb begin
    st_nx = st;
    score_nx = score;
    high_nx = high;
    new_high_nx = new_high;
    alt_nx = '0;
    blink_nx = '0;
    blank_nx = 1'b0;
    if (game_start) begin
      st_nx = PLAY;
      score_nx = '0;
      new_high_nx = 1'b0;
    end else begin
      case (st)
        IDLE: st_nx = IDLE;
        PLAY: begin
          score_nx = score_inc;
          if (game_over) begin
            st_nx = SHOW_SCORE;
            if (score_inc > high) begin
              high_nx = score_inc;
              new_high_nx = 1'b1;
            end
          end
        end
        SHOW_SCORE: begin
          st_nx = (alt_cnt == ALT_LAST) ? SHOW_HIGH : SHOW_SCORE;
          alt_nx = (alt_cnt == ALT_LAST) ? '0 : alt_cnt + 1'b1;
        end
        SHOW_HIGH: begin
          st_nx = (alt_cnt == ALT_LAST) ? SHOW_SCORE : SHOW_HIGH;
          alt_nx = (alt_cnt == ALT_LAST) ? '0 : alt_cnt + 1'b1;
          if (alt_cnt != ALT_LAST && new_high) begin
            blink_nx = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            blank_nx = (blink_cnt == BLINK_LAST) ? ~blank : blank;
          end
        end
      endcase
    end
  end
  assign sel_nx = (st_nx == IDLE) || (st_nx == SHOW_HIGH);
  assign disp_nx = sel_nx ? high : score;
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      st <= IDLE;
      score <= '0;
      high <= '0;
      disp_bcd <= '0;
      blank <= 1'b0;
      disp_sel <= 1'b1;
      new_high <= 1'b0;
      alt_cnt <= '0;
      blink_cnt <= '0;
    end else begin
      st <= st_nx;
      score <= score_nx;
      high <= high_nx;
      disp_bcd <= disp_nx;
      blank <= blank_nx;
      disp_sel <= sel_nx;
      new_high <= new_high_nx;
      alt_cnt <= alt_nx;
      blink_cnt <= blink_nx;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed and random stimulus against a decimal-arithmetic reference model.
module tb_score_display_ctrl;
  localparam int ALT = 8;
  localparam int BLK = 2;
  logic clk = 1'b0;
  logic reset, game_start, game_over, inc_valid;
  logic [3:0] inc_amt;
  logic [15:0] disp_bcd;
  logic blank, disp_sel, new_high;
  logic [1:0] state;
  int n_tests = 0;
  int n_fail = 0;
  int m_state, m_score, m_high, m_t;
  bit m_new;
  bit [7:0] pat;
  bit found;
  always #5 clk = ~clk;
  score_display_ctrl #(.ALT_PERIOD(ALT), .BLINK_PERIOD(BLK)) dut (
    .CLK100MHZ(clk), .reset(reset), .game_start(game_start), .game_over(game_over),
    .inc_valid(inc_valid), .inc_amt(inc_amt), .disp_bcd(disp_bcd), .blank(blank),
    .disp_sel(disp_sel), .new_high(new_high), .state(state)
  );
  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(bit rst, bit gs, bit go, bit iv, logic [3:0] amt);
    int a, o_s, o_h;
    bit sel;
    reset = rst;
    game_start = gs;
    game_over = go;
    inc_valid = iv;
    inc_amt = amt;
    @(posedge clk);
    o_s = m_score;
    o_h = m_high;
    if (rst) begin
      m_state = 0; m_score = 0; m_high = 0; m_new = 0; m_t = 0;
    end else if (gs) begin
      m_state = 1; m_score = 0; m_new = 0;
    end else if (m_state == 1) begin
      a = (amt > 9) ? 9 : int'(amt);
      if (iv) m_score = (m_score + a > 9999) ? 9999 : m_score + a;
      if (go) begin
        m_state = 2;
        m_t = 0;
        if (m_score > m_high) begin
          m_high = m_score;
          m_new = 1;
        end
      end
    end else if (m_state >= 2) begin
      m_t++;
      m_state = ((m_t / ALT) % 2) ? 3 : 2;
    end
    sel = (m_state == 0) || (m_state == 3);
    #1;
    check("state", state, m_state);
    check("disp_sel", disp_sel, sel);
    check("new_high", new_high, m_new);
    check("blank", blank, (m_state == 3 && m_new && ((m_t % ALT) / BLK) % 2 == 1));
    check("disp_bcd", disp_bcd, rst ? 16'h0 : (sel ? to_bcd(o_h) : to_bcd(o_s)));
  endtask
  task automatic add42();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'd9);
    step(0, 0, 0, 1, 4'd6);
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_disp_sel", disp_sel, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 4'd7);
    step(0, 0, 0, 1, 4'd5);
    step(0, 0, 0, 1, 4'd9);
    step(0, 0, 0, 0, 0);
    check("sum21", disp_bcd, 16'h0021);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 4'd12);
    step(0, 0, 0, 0, 0);
    check("amt12", disp_bcd, 16'h0009);
    for (int i = 0; i < 1110; i++) step(0, 0, 0, 1, 4'd9);
    step(0, 0, 0, 1, 4'd5);
    step(0, 0, 0, 1, 4'd9);
    step(0, 0, 0, 1, 4'd3);
    step(0, 0, 0, 1, 4'd12);
    step(0, 0, 0, 0, 0);
    check("sat", disp_bcd, 16'h9999);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    add42();
    step(0, 0, 1, 0, 0);
    check("go_new_high", new_high, 1);
    for (int i = 0; i < ALT; i++) step(0, 0, 0, 0, 0);
    check("show_high", state, 3);
    for (int i = 0; i < ALT; i++) begin
      pat[i] = blank;
      step(0, 0, 0, 0, 0);
    end
    check("blink_pat", pat, 8'b11001100);
    check("back_score", state, 2);
    step(0, 1, 0, 0, 0);
    add42();
    step(0, 0, 1, 0, 0);
    check("equal_no_new", new_high, 0);
    for (int i = 0; i < 2 * ALT; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 4'd5);
    step(0, 1, 1, 0, 0);
    check("start_wins", state, 1);
    step(0, 0, 0, 1, 4'd3);
    step(0, 1, 0, 1, 4'd7);
    step(0, 0, 0, 0, 0);
    check("inc_dropped", disp_bcd, 16'h0000);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    add42();
    step(0, 0, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      found = (state == 2'd3) && blank;
    end
    check("blink_wait", found, 1);
    step(1, 0, 0, 0, 0);
    check("rst_high_state", state, 0);
    check("rst_high_disp", disp_bcd, 16'h0000);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
